// File: rtl/hs_fifo_stage.sv
// hs_fifo_stage: elastic buffer between two trigger/ready handshake stages.
// Latency: a word accepted at edge N is visible on dataOut/readyOut after edge N.
// Backpressure: requests upstream only while not full; readyOut drops for a cycle after each pop.
//
// Ports:
//   clk, reset           sole clock, synchronous active-high reset
//   triggerIn            downstream toggle, each change pops the head word
//   readyOut, dataOut    registered head-valid flag and head word
//   triggerOut           upstream toggle, each change requests one word
//   readyIn, dataIn      upstream word valid (level) and word
//   level                current occupancy
//   flush                branch-redirect clear, only with HS_FIFO_STAGE_FLUSH_EN defined
module hs_fifo_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       triggerIn,
  output logic                       readyOut,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       triggerOut,
  input  logic                       readyIn,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef HS_FIFO_STAGE_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LOW  = 2'd1;
  localparam logic [1:0] WAIT_HIGH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             trig_q;
  logic             trig_out_q, trig_out_d;
  logic             ready_out_q, ready_out_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic pop;
  logic accept;
  logic push;

`ifdef HS_FIFO_STAGE_FLUSH_EN
  logic drop_q, drop_d;
`endif

  always_comb begin
    pop    = (triggerIn != trig_q) && ready_out_q;
    accept = (state_q == WAIT_HIGH) && readyIn;
`ifdef HS_FIFO_STAGE_FLUSH_EN
    // A word requested before a flush still completes the handshake but is discarded.
    push   = accept && !drop_q && !flush;
`else
    push   = accept;
`endif

    state_d    = state_q;
    trig_out_d = trig_out_q;
    case (state_q)
      IDLE: begin
        // Pre-pop occupancy: at most one request is outstanding, so this never overflows.
        if (count_q < CW'(DEPTH)) begin
          trig_out_d = ~trig_out_q;
          state_d    = WAIT_LOW;
        end
      end
      // Insist on seeing readyIn low first so a stale high from the last word is not reused.
      WAIT_LOW:  if (!readyIn) state_d = WAIT_HIGH;
      WAIT_HIGH: if (readyIn)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    ready_out_d = (count_d != '0) && !pop;

    // Head word after this edge; a push landing at the new head slot is forwarded directly.
    data_out_d = data_out_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) data_out_d = dataIn;
      else                                data_out_d = mem_q[rd_ptr_d];
    end

`ifdef HS_FIFO_STAGE_FLUSH_EN
    drop_d = drop_q;
    if (accept) drop_d = 1'b0;
    if (flush) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ready_out_d = 1'b0;
      data_out_d  = data_out_q;
      // Only a request that has not completed on this very edge leaves a word in flight.
      if ((state_q == WAIT_LOW) || ((state_q == WAIT_HIGH) && !readyIn)) drop_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_q      <= triggerIn;  // capture so the first observed level is not a pop
      trig_out_q  <= 1'b0;
      ready_out_q <= 1'b0;
      data_out_q  <= '0;
`ifdef HS_FIFO_STAGE_FLUSH_EN
      drop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_q      <= triggerIn;
      trig_out_q  <= trig_out_d;
      ready_out_q <= ready_out_d;
      data_out_q  <= data_out_d;
`ifdef HS_FIFO_STAGE_FLUSH_EN
      drop_q      <= drop_d;
`endif
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= dataIn;
  end

  assign readyOut   = ready_out_q;
  assign dataOut    = data_out_q;
  assign triggerOut = trig_out_q;
  assign level      = count_q;

endmodule

// File: tb/tb_hs_fifo_stage.sv
module tb_hs_fifo_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        triggerIn = 1'b0;
  logic        readyIn = 1'b1;
  logic [31:0] dataIn = '0;
  logic        readyOut;
  logic [31:0] dataOut;
  logic        triggerOut;
  logic [2:0]  level;
`ifdef HS_FIFO_STAGE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int   total = 0;
  int   bad = 0;
  int   toggles = 0;
  int   served = 0;
  int   t0 = 0;
  logic last_trig = 1'b0;

  always #5 clk = ~clk;

  hs_fifo_stage #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .triggerIn  (triggerIn),
    .readyOut   (readyOut),
    .dataOut    (dataOut),
    .triggerOut (triggerOut),
    .readyIn    (readyIn),
    .dataIn     (dataIn),
    .level      (level)
`ifdef HS_FIFO_STAGE_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1ns later and count every triggerOut change.
  task automatic step();
    @(posedge clk);
    #1;
    if (triggerOut !== last_trig) begin
      toggles++;
      last_trig = triggerOut;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    toggles = 0;
    served = 0;
    last_trig = 1'b0;
  endtask

  // Answer the next outstanding request: readyIn low for a cycle, then high with the word.
  task automatic supply(input logic [31:0] w, input logic pop_too);
    for (int i = 0; i < 50 && toggles <= served; i++) step();
    check("req_seen", 32'(toggles > served), 32'd1);
    readyIn = 1'b0;
    step();
    readyIn = 1'b1;
    dataIn = w;
    if (pop_too) triggerIn = ~triggerIn;
    step();
    served++;
  endtask

  initial begin
    // Reset held with upstream stuck high.
    step();
    step();
    step();
    check("rst_trig", 32'(triggerOut), 32'd0);
    check("rst_ready", 32'(readyOut), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", dataOut, 32'd0);
    reset = 1'b0;
    toggles = 0;
    served = 0;
    last_trig = 1'b0;
    step();
    check("trig_first_edge", 32'(triggerOut), 32'd1);
    step();
    step();
    step();
    check("stale_high_no_accept", 32'(level), 32'd0);
    supply(32'hE3A00001, 1'b0);
    check("first_level", 32'(level), 32'd1);
    check("first_ready", 32'(readyOut), 32'd1);
    check("first_data", dataOut, 32'hE3A00001);

    // Fill to full.
    do_reset();
    for (int i = 1; i <= 4; i++) supply(32'(i), 1'b0);
    check("fill_level", 32'(level), 32'd4);
    check("fill_toggles", 32'(toggles), 32'd4);
    t0 = toggles;
    for (int i = 0; i < 20; i++) step();
    check("full_trig_hold", 32'(toggles - t0), 32'd0);
    check("full_level_hold", 32'(level), 32'd4);

    // Drain in order.
    t0 = toggles;
    for (int i = 1; i <= 4; i++) begin
      check("drain_ready", 32'(readyOut), 32'd1);
      check("drain_data", dataOut, 32'(i));
      triggerIn = ~triggerIn;
      step();
      check("pop_ready_low", 32'(readyOut), 32'd0);
      check("pop_level", 32'(level), 32'(4 - i));
      step();
      check("pop_ready_next", 32'(readyOut), 32'(i < 4));
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_one_request", 32'(toggles - t0), 32'd1);

    // Toggle while empty is ignored.
    triggerIn = ~triggerIn;
    step();
    check("empty_pop_level", 32'(level), 32'd0);
    step();
    step();
    check("empty_pop_ready", 32'(readyOut), 32'd0);
    supply(32'h77, 1'b0);
    check("after_empty_ready", 32'(readyOut), 32'd1);
    check("after_empty_data", dataOut, 32'h77);
    step();
    step();
    step();
    check("no_auto_consume_level", 32'(level), 32'd1);
    check("no_auto_consume_ready", 32'(readyOut), 32'd1);

    // Simultaneous push and pop at level 2.
    supply(32'h78, 1'b0);
    check("lvl2", 32'(level), 32'd2);
    supply(32'h79, 1'b1);
    check("pushpop_level", 32'(level), 32'd2);
    check("pushpop_ready", 32'(readyOut), 32'd0);
    step();
    check("pushpop_head_ready", 32'(readyOut), 32'd1);
    check("pushpop_head", dataOut, 32'h78);
    triggerIn = ~triggerIn;
    step();
    step();
    check("pushpop_next", dataOut, 32'h79);
    check("pushpop_next_level", 32'(level), 32'd1);

`ifdef HS_FIFO_STAGE_FLUSH_EN
    // Flush with a request in WAIT_HIGH; the in-flight word must vanish.
    do_reset();
    for (int i = 1; i <= 3; i++) supply(32'(i), 1'b0);
    check("pre_flush_level", 32'(level), 32'd3);
    for (int i = 0; i < 50 && toggles <= served; i++) step();
    check("flush_req_seen", 32'(toggles > served), 32'd1);
    readyIn = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_ready", 32'(readyOut), 32'd0);
    readyIn = 1'b1;
    dataIn = 32'hDEAD;
    step();
    served++;
    check("drop_level", 32'(level), 32'd0);
    check("drop_ready", 32'(readyOut), 32'd0);
    supply(32'h5, 1'b0);
    check("post_flush_data", dataOut, 32'h5);
    check("post_flush_ready", 32'(readyOut), 32'd1);
    check("post_flush_level", 32'(level), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
